fir_multicore_scheduler: RTL and testbench

//  Dispatches NUM_SAMPLES FIR sample jobs across NUM_CORES processor cores; each core runs the FIR kernel.
//  Per job: programs x10/x11/x12 of the chosen core via the shared external RF write port, then pulses that core's start.

---
 rtl/fir_sched_pkg.sv | 26 ++
 rtl/rr_free_picker.sv | 35 +++
 rtl/fir_multicore_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_fir_multicore_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// ============================================================================
// fir_sched_pkg : shared types and RF register indices for the FIR scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package fir_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PICK    = 3'd1,
      S_SET_IN  = 3'd2,
      S_SET_CO  = 3'd3,
      S_SET_OUT = 3'd4,
      S_START   = 3'd5,
      S_DRAIN   = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   localparam logic [4:0] REG_IN  = 5'd10;
   localparam logic [4:0] REG_CO  = 5'd11;
   localparam logic [4:0] REG_OUT = 5'd12;

endpackage

`default_nettype wire

// File: rtl/rr_free_picker.sv
// ============================================================================
// rr_free_picker : first non-busy core, searching upward from rr_ptr (wrapping)
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_free_picker #(
   parameter int NUM_CORES = 2,
   parameter int PW        = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] core_busy,
   input  logic [PW-1:0]        rr_ptr,
   output logic                 found,
   output logic [PW-1:0]        idx
);

   logic [PW-1:0] cand;

   // NUM_CORES is a power of two, so PW-bit addition wraps modulo NUM_CORES
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand = rr_ptr + PW'(k);
         if (!found && !core_busy[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fir_multicore_scheduler.sv
// ============================================================================
// fir_multicore_scheduler : dispatches FIR sample jobs round-robin over cores
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_multicore_scheduler
   import fir_sched_pkg::*;
#(
   parameter int          NUM_CORES   = 2,
   parameter int          NUM_SAMPLES = 16,
   parameter logic [31:0] INPUT_BASE  = 32'h0000_0000,
   parameter logic [31:0] COEFF_BASE  = 32'h0000_0040,
   parameter logic [31:0] OUTPUT_BASE = 32'h0000_0080
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 go,
   output logic                 busy,
   output logic                 all_done,
   output logic                 spurious_done,
   output logic [NUM_CORES-1:0] core_start,
   input  logic [NUM_CORES-1:0] core_done,
   output logic                 rf_we,
   output logic [NUM_CORES-1:0] rf_core_sel,
   output logic [4:0]           rf_waddr,
   output logic [31:0]          rf_wdata
);

   localparam int IW = $clog2(NUM_SAMPLES + 1);
   localparam int PW = $clog2(NUM_CORES);
   localparam logic [IW-1:0] C_NUM_SAMPLES = IW'(NUM_SAMPLES);

   state_t               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [IW-1:0]        done_cnt_q, done_cnt_d;
   logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]        target_q, target_d;
   logic                 spurious_q, spurious_d;

   logic                 pick_found;
   logic [PW-1:0]        pick_idx;
   logic [NUM_CORES-1:0] done_valid;
   logic [NUM_CORES-1:0] done_spur;
   logic [IW-1:0]        done_inc;
   logic [NUM_CORES-1:0] tgt_oh;
   logic [31:0]          idx_offs;

   rr_free_picker #(
      .NUM_CORES (NUM_CORES),
      .PW        (PW)
   ) u_picker (
      .core_busy (core_busy_q),
      .rr_ptr    (rr_ptr_q),
      .found     (pick_found),
      .idx       (pick_idx)
   );

   always_comb begin
      done_valid = core_done & core_busy_q;
      done_spur  = core_done & ~core_busy_q;
      done_inc   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         done_inc = done_inc + IW'(done_valid[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      done_cnt_d  = done_cnt_q;
      core_busy_d = core_busy_q;
      rr_ptr_d    = rr_ptr_q;
      target_d    = target_q;
      spurious_d  = spurious_q;

      // Completions are accepted in every state except IDLE, including while dispatching
      if (state_q != S_IDLE) begin
         core_busy_d = core_busy_q & ~done_valid;
         done_cnt_d  = done_cnt_q + done_inc;
         if (|done_spur) begin
            spurious_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (go) begin
               state_d     = S_PICK;
               idx_d       = '0;
               done_cnt_d  = '0;
               core_busy_d = '0;
               rr_ptr_d    = '0;
            end
         end
         S_PICK: begin
            if (idx_q == C_NUM_SAMPLES) begin
               state_d = S_DRAIN;
            end else if (pick_found) begin
               target_d = pick_idx;
               state_d  = S_SET_IN;
            end
         end
         S_SET_IN:  state_d = S_SET_CO;
         S_SET_CO:  state_d = S_SET_OUT;
         S_SET_OUT: state_d = S_START;
         S_START: begin
            core_busy_d[target_q] = 1'b1;
            idx_d    = idx_q + 1'b1;
            rr_ptr_d = target_q + 1'b1;
            state_d  = S_PICK;
         end
         S_DRAIN: begin
            if (done_cnt_q == C_NUM_SAMPLES) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tgt_oh           = '0;
      tgt_oh[target_q] = 1'b1;
      idx_offs         = 32'(idx_q) << 2;

      busy          = (state_q != S_IDLE) && (state_q != S_DONE);
      all_done      = (state_q == S_DONE);
      spurious_done = spurious_q;
      core_start    = '0;
      rf_we         = 1'b0;
      rf_core_sel   = '0;
      rf_waddr      = '0;
      rf_wdata      = '0;

      case (state_q)
         S_SET_IN: begin
            rf_we       = 1'b1;
            rf_core_sel = tgt_oh;
            rf_waddr    = REG_IN;
            rf_wdata    = INPUT_BASE + idx_offs;
         end
         S_SET_CO: begin
            rf_we       = 1'b1;
            rf_core_sel = tgt_oh;
            rf_waddr    = REG_CO;
            rf_wdata    = COEFF_BASE;
         end
         S_SET_OUT: begin
            rf_we       = 1'b1;
            rf_core_sel = tgt_oh;
            rf_waddr    = REG_OUT;
            rf_wdata    = OUTPUT_BASE + idx_offs;
         end
         S_START: core_start = tgt_oh;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         done_cnt_q  <= '0;
         core_busy_q <= '0;
         rr_ptr_q    <= '0;
         target_q    <= '0;
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         done_cnt_q  <= done_cnt_d;
         core_busy_q <= core_busy_d;
         rr_ptr_q    <= rr_ptr_d;
         target_q    <= target_d;
         spurious_q  <= spurious_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fir_multicore_scheduler.sv
// ============================================================================
// tb_fir_multicore_scheduler : directed bench, 2 cores, 4 samples per run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_multicore_scheduler;

   localparam int N = 2;
   localparam int S = 4;

   typedef struct {
      logic [1:0]  sel;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        go;
   logic        busy;
   logic        all_done;
   logic        spurious_done;
   logic [1:0]  core_start;
   logic [1:0]  core_done;
   logic        rf_we;
   logic [1:0]  rf_core_sel;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks   = 0;
   int failures = 0;
   int tcount   = 0;
   int cnt[2];
   bit auto_en  = 1'b0;
   int auto_pulses = 0;
   int idle_viol = 0;
   wr_t wlog[$];
   int  slog_tgt[$];
   int  slog_t[$];

   fir_multicore_scheduler #(
      .NUM_CORES   (N),
      .NUM_SAMPLES (S),
      .INPUT_BASE  (32'h0000_0000),
      .COEFF_BASE  (32'h0000_0040),
      .OUTPUT_BASE (32'h0000_0080)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .go            (go),
      .busy          (busy),
      .all_done      (all_done),
      .spurious_done (spurious_done),
      .core_start    (core_start),
      .core_done     (core_done),
      .rf_we         (rf_we),
      .rf_core_sel   (rf_core_sel),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, log RF writes and starts, and run the auto-reply core model
   task automatic tick();
      @(posedge clock);
      #1;
      tcount++;
      core_done = '0;
      if (auto_en) begin
         for (int i = 0; i < N; i++) begin
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) begin
                  core_done[i] = 1'b1;
                  auto_pulses++;
               end
            end
         end
      end
      if (rf_we) wlog.push_back('{rf_core_sel, rf_waddr, rf_wdata});
      else if (rf_core_sel != 0 || rf_wdata != 0) idle_viol++;
      for (int i = 0; i < N; i++) begin
         if (core_start[i]) begin
            slog_tgt.push_back(i);
            slog_t.push_back(tcount);
            if (auto_en) cnt[i] = 10;
         end
      end
   endtask

   task automatic clear_logs();
      wlog.delete();
      slog_tgt.delete();
      slog_t.delete();
      idle_viol = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_all_done"}, 32'(all_done), 32'd0);
      chk({tag, "_spurious"}, 32'(spurious_done), 32'd0);
      chk({tag, "_start"}, 32'(core_start), 32'd0);
      chk({tag, "_we"}, 32'(rf_we), 32'd0);
      chk({tag, "_sel"}, 32'(rf_core_sel), 32'd0);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
      chk({tag, "_wdata"}, rf_wdata, 32'd0);
   endtask

   initial begin
      int guard;
      reset = 1'b1;
      go = 1'b0;
      core_done = '0;
      cnt[0] = 0;
      cnt[1] = 0;

      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Test 1: cores reply 10 cycles after start
      clear_logs();
      auto_en = 1'b1;
      tcount = 0;
      go = 1'b1;
      tick();
      go = 1'b0;
      guard = 0;
      while (!all_done && guard < 300) begin
         tick();
         guard++;
      end
      chk("t1_all_done", 32'(all_done), 32'd1);
      chk("t1_done_pulses", 32'(auto_pulses), 32'd4);
      chk("t1_busy_in_done", 32'(busy), 32'd0);
      chk("t1_nwrites", 32'(wlog.size()), 32'd12);
      chk("t1_nstarts", 32'(slog_tgt.size()), 32'd4);
      for (int j = 0; j < 4; j++) begin
         logic [1:0] esel;
         esel = (j % 2 == 0) ? 2'b01 : 2'b10;
         if (3 * j + 2 < wlog.size()) begin
            chk($sformatf("t1_j%0d_in_sel", j), 32'(wlog[3*j].sel), 32'(esel));
            chk($sformatf("t1_j%0d_in_addr", j), 32'(wlog[3*j].addr), 32'd10);
            chk($sformatf("t1_j%0d_in_data", j), wlog[3*j].data, 32'(4 * j));
            chk($sformatf("t1_j%0d_co_addr", j), 32'(wlog[3*j+1].addr), 32'd11);
            chk($sformatf("t1_j%0d_co_data", j), wlog[3*j+1].data, 32'h40);
            chk($sformatf("t1_j%0d_out_addr", j), 32'(wlog[3*j+2].addr), 32'd12);
            chk($sformatf("t1_j%0d_out_data", j), wlog[3*j+2].data, 32'h80 + 32'(4 * j));
            chk($sformatf("t1_j%0d_out_sel", j), 32'(wlog[3*j+2].sel), 32'(esel));
         end
         if (j < slog_tgt.size()) begin
            chk($sformatf("t1_j%0d_start_tgt", j), 32'(slog_tgt[j]), 32'(j % 2));
         end
      end
      if (slog_t.size() >= 2) begin
         chk("t1_first_start_cycle", 32'(slog_t[0]), 32'd5);
         chk("t1_job_spacing", 32'(slog_t[1] - slog_t[0]), 32'd5);
      end
      chk("t1_idle_rf_zero", 32'(idle_viol), 32'd0);
      chk("t1_spurious", 32'(spurious_done), 32'd0);
      auto_en = 1'b0;

      // Test 2: no completions, scheduler stalls in PICK
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_logs();
      go = 1'b1;
      tick();
      go = 1'b0;
      repeat (25) tick();
      chk("t2_nwrites_stalled", 32'(wlog.size()), 32'd6);
      chk("t2_nstarts_stalled", 32'(slog_tgt.size()), 32'd2);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_we_stalled", 32'(rf_we), 32'd0);
      core_done = 2'b10;
      tick();
      chk("t2_we_done_cycle", 32'(rf_we), 32'd0);
      tick();
      chk("t2_job2_we", 32'(rf_we), 32'd1);
      chk("t2_job2_sel", 32'(rf_core_sel), 32'b10);
      chk("t2_job2_addr", 32'(rf_waddr), 32'd10);
      chk("t2_job2_data", rf_wdata, 32'h8);

      // Test 3: simultaneous completions from both busy cores
      tick();
      tick();
      tick();
      chk("t3_start_c1", 32'(core_start), 32'b10);
      tick();
      core_done = 2'b11;
      tick();
      tick();
      chk("t3_job3_sel", 32'(rf_core_sel), 32'b01);
      chk("t3_job3_data", rf_wdata, 32'hC);
      tick();
      tick();
      tick();
      chk("t3_start_c0", 32'(core_start), 32'b01);
      tick();
      core_done = 2'b01;
      tick();
      chk("t3_not_done_yet", 32'(all_done), 32'd0);
      tick();
      chk("t3_all_done", 32'(all_done), 32'd1);
      chk("t3_spurious", 32'(spurious_done), 32'd0);

      // Test 4: done from an idle core
      core_done = 2'b01;
      tick();
      chk("t4_spurious_set", 32'(spurious_done), 32'd1);
      chk("t4_still_done", 32'(all_done), 32'd1);
      repeat (3) tick();
      chk("t4_spurious_held", 32'(spurious_done), 32'd1);

      // Test 6: go in DONE restarts; go mid-run ignored
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("t6_all_done_drop", 32'(all_done), 32'd0);
      chk("t6_busy", 32'(busy), 32'd1);
      chk("t6_spurious_sticky", 32'(spurious_done), 32'd1);
      tick();
      chk("t6_in_addr", 32'(rf_waddr), 32'd10);
      chk("t6_in_data", rf_wdata, 32'h0);
      chk("t6_in_sel", 32'(rf_core_sel), 32'b01);
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      chk("t6_go_ignored_addr", 32'(rf_waddr), 32'd12);
      chk("t6_go_ignored_data", rf_wdata, 32'h80);

      // Test 5: reset while in SET_CO of the second job
      tick();
      tick();
      tick();
      tick();
      chk("t5_co_addr", 32'(rf_waddr), 32'd11);
      chk("t5_co_sel", 32'(rf_core_sel), 32'b10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_all_zero("t5_after_reset");
      tick();
      chk("t5_idle_busy", 32'(busy), 32'd0);
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      chk("t5_restart_addr", 32'(rf_waddr), 32'd10);
      chk("t5_restart_data", rf_wdata, 32'h0);
      chk("t5_restart_sel", 32'(rf_core_sel), 32'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
